// File: rtl/rot_pipe_if.sv
// Stream bundle for rot_pipe: input word/amount/mode with
// valid/ready on the way in, result with valid/ready on the way out.
interface rot_pipe_if #(
  parameter int N      = 64,
  parameter int LOG2_N = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [0:N-1]      in_data;
  logic [0:LOG2_N-1] in_amt;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [0:N-1]      out_data;

  modport master (
    output in_valid,
    output in_data,
    output in_amt,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_amt,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/rot_pipe.sv
// Pipelined log-stage rotator/shifter: LOG2_N mux stages split into
// register ranks of REG_EVERY stages, with a stall-all valid/ready pipe.
module rot_pipe #(
  parameter int N         = 64,
  parameter int LOG2_N    = 6,
  parameter int REG_EVERY = 2
) (
  input logic       clk,
  input logic       rst,
  rot_pipe_if.slave bus
);
  localparam int L = (LOG2_N + REG_EVERY - 1) / REG_EVERY;

  typedef logic [0:N-1]      word_t;
  typedef logic [0:LOG2_N-1] amt_t;

  word_t      data_q [L];
  word_t      data_d [L];
  amt_t       amt_q  [L];
  amt_t       amt_d  [L];
  logic [1:0] mode_q [L];
  logic [1:0] mode_d [L];
  logic       fill_q [L];
  logic       fill_d [L];
  logic       vld_q  [L];
  logic       vld_d  [L];
  logic       adv;

  function automatic word_t stage_f(
    input word_t      d,
    input int         s,
    input logic       en,
    input logic [1:0] mode,
    input logic       fill
  );
    word_t o;
    int    sh;
    int    idx;
    o  = d;
    sh = N >> (s + 1);
    if (en) begin
      for (int k = 0; k < N; k++) begin
        case (mode)
          2'b00: begin
            idx  = (k - sh + N) % N;
            o[k] = d[idx];
          end
          2'b01: begin
            idx  = (k + sh) % N;
            o[k] = d[idx];
          end
          default: begin
            // SHR fills with 0, SAR with the bit captured at acceptance
            idx  = (k - sh + N) % N;
            o[k] = (k >= sh) ? d[idx] : (mode[0] & fill);
          end
        endcase
      end
    end
    return o;
  endfunction

  assign adv = bus.out_ready | ~vld_q[L-1];

  always_comb begin
    word_t      sd;
    amt_t       sa;
    logic [1:0] sm;
    logic       sf;
    logic       sv;
    int         p;
    for (int r = 0; r < L; r++) begin
      p = (r == 0) ? 0 : r - 1;
      if (r == 0) begin
        sd = bus.in_data;
        sa = bus.in_amt;
        sm = bus.in_mode;
        sf = bus.in_data[0];
        sv = bus.in_valid;
      end else begin
        sd = data_q[p];
        sa = amt_q[p];
        sm = mode_q[p];
        sf = fill_q[p];
        sv = vld_q[p];
      end
      for (int s = 0; s < LOG2_N; s++) begin
        if (s / REG_EVERY == r) begin
          sd = stage_f(sd, s, sa[s], sm, sf);
        end
      end
      data_d[r] = data_q[r];
      amt_d[r]  = amt_q[r];
      mode_d[r] = mode_q[r];
      fill_d[r] = fill_q[r];
      vld_d[r]  = vld_q[r];
      if (adv) begin
        data_d[r] = sd;
        amt_d[r]  = sa;
        mode_d[r] = sm;
        fill_d[r] = sf;
        vld_d[r]  = sv;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < L; r++) begin
        data_q[r] <= '0;
        amt_q[r]  <= '0;
        mode_q[r] <= '0;
        fill_q[r] <= 1'b0;
        vld_q[r]  <= 1'b0;
      end
    end else begin
      for (int r = 0; r < L; r++) begin
        data_q[r] <= data_d[r];
        amt_q[r]  <= amt_d[r];
        mode_q[r] <= mode_d[r];
        fill_q[r] <= fill_d[r];
        vld_q[r]  <= vld_d[r];
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[L-1];
  assign bus.out_data  = data_q[L-1];
endmodule

// File: tb/tb_rot_pipe.sv
// Self-checking bench for rot_pipe: three configurations, directed
// scenarios on N=8 and randomized traffic on N=64 and N=16.
module tb_rot_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rot_pipe_if #(.N(8),  .LOG2_N(3)) ifa();
  rot_pipe_if #(.N(64), .LOG2_N(6)) ifb();
  rot_pipe_if #(.N(16), .LOG2_N(4)) ifc();

  rot_pipe #(.N(8), .LOG2_N(3), .REG_EVERY(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  rot_pipe #(.N(64), .LOG2_N(6), .REG_EVERY(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));
  rot_pipe #(.N(16), .LOG2_N(4), .REG_EVERY(4)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc.slave));

  int checks = 0;
  int errors = 0;
  logic [0:63] qa[$];
  logic [0:63] qb[$];
  logic [0:63] qc[$];
  int push_a = 0, pop_a = 0;
  int push_b = 0, pop_b = 0;
  int push_c = 0, pop_c = 0;

  // Reference: direct rotate/shift by the whole amount
  function automatic logic [0:63] ref_f(
    input logic [0:63] d,
    input int          n,
    input int          a,
    input logic [1:0]  m
  );
    logic [0:63] r;
    r = '0;
    for (int k = 0; k < n; k++) begin
      case (m)
        2'b00: r[k] = d[(k - a + n) % n];
        2'b01: r[k] = d[(k + a) % n];
        2'b10: if (k >= a) r[k] = d[k - a]; else r[k] = 1'b0;
        default: if (k >= a) r[k] = d[k - a]; else r[k] = d[0];
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin : mon_a
    logic [0:63] e;
    logic [0:63] x;
    if (!rst) begin
      if (ifa.out_valid && ifa.out_ready) begin
        x = '0;
        for (int k = 0; k < 8; k++) x[k] = ifa.out_data[k];
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL sb_a: unexpected output %h, expected none", x);
        end else begin
          e = qa.pop_front();
          pop_a++;
          if (x !== e) begin
            errors++;
            $display("FAIL sb_a: got %h expected %h", x, e);
          end
        end
      end
      if (ifa.in_valid && ifa.in_ready) begin
        e = '0;
        for (int k = 0; k < 8; k++) e[k] = ifa.in_data[k];
        qa.push_back(ref_f(e, 8, int'(ifa.in_amt), ifa.in_mode));
        push_a++;
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [0:63] e;
    logic [0:63] x;
    if (!rst) begin
      if (ifb.out_valid && ifb.out_ready) begin
        x = ifb.out_data;
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL sb_b: unexpected output %h, expected none", x);
        end else begin
          e = qb.pop_front();
          pop_b++;
          if (x !== e) begin
            errors++;
            $display("FAIL sb_b: got %h expected %h", x, e);
          end
        end
      end
      if (ifb.in_valid && ifb.in_ready) begin
        qb.push_back(ref_f(ifb.in_data, 64, int'(ifb.in_amt), ifb.in_mode));
        push_b++;
      end
    end
  end

  always @(negedge clk) begin : mon_c
    logic [0:63] e;
    logic [0:63] x;
    if (!rst) begin
      if (ifc.out_valid && ifc.out_ready) begin
        x = '0;
        for (int k = 0; k < 16; k++) x[k] = ifc.out_data[k];
        checks++;
        if (qc.size() == 0) begin
          errors++;
          $display("FAIL sb_c: unexpected output %h, expected none", x);
        end else begin
          e = qc.pop_front();
          pop_c++;
          if (x !== e) begin
            errors++;
            $display("FAIL sb_c: got %h expected %h", x, e);
          end
        end
      end
      if (ifc.in_valid && ifc.in_ready) begin
        e = '0;
        for (int k = 0; k < 16; k++) e[k] = ifc.in_data[k];
        qc.push_back(ref_f(e, 16, int'(ifc.in_amt), ifc.in_mode));
        push_c++;
      end
    end
  end

  task automatic idle_all();
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_amt = '0;
    ifa.in_mode = '0;    ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_amt = '0;
    ifb.in_mode = '0;    ifb.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_amt = '0;
    ifc.in_mode = '0;    ifc.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.out_data !== 8'h00 || ifa.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_a: v=%b d=%h rdy=%b required 0 00 1",
               ifa.out_valid, ifa.out_data, ifa.in_ready);
    end
    checks++;
    if (ifb.out_valid !== 1'b0 || ifb.out_data !== 64'h0 || ifb.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_b: v=%b d=%h rdy=%b required 0 0 1",
               ifb.out_valid, ifb.out_data, ifb.in_ready);
    end
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.out_data !== 16'h0 || ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_c: v=%b d=%h rdy=%b required 0 0 1",
               ifc.out_valid, ifc.out_data, ifc.in_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_modes();
    logic [0:7] d_t [8] = '{8'b10000001, 8'b10000001, 8'b10110000, 8'b10110000,
                            8'b10110101, 8'b10110101, 8'b10110000, 8'b10110000};
    logic [0:2] a_t [8] = '{3'b001, 3'b001, 3'b011, 3'b010,
                            3'b000, 3'b000, 3'b111, 3'b111};
    logic [1:0] m_t [8] = '{2'b00, 2'b01, 2'b10, 2'b11,
                            2'b01, 2'b11, 2'b10, 2'b11};
    logic [0:7] x_t [8] = '{8'b11000000, 8'b00000011, 8'b00010110, 8'b11101100,
                            8'b10110101, 8'b10110101, 8'b00000001, 8'b11111111};
    int lat;
    for (int i = 0; i < 8; i++) begin
      ifa.in_data  = d_t[i];
      ifa.in_amt   = a_t[i];
      ifa.in_mode  = m_t[i];
      ifa.in_valid = 1'b1;
      @(posedge clk);
      #1 ifa.in_valid = 1'b0;
      lat = 1;
      while (!ifa.out_valid && lat < 10) begin
        @(posedge clk);
        #1 lat++;
      end
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL latency_%0d: got %0d required 3", i, lat);
      end
      checks++;
      if (ifa.out_data !== x_t[i]) begin
        errors++;
        $display("FAIL mode_%0d: got %b required %b", i, ifa.out_data, x_t[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [0:7] v = 8'b10000000;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ifa.in_data  = v;
          ifa.in_amt   = 3'(i);
          ifa.in_mode  = 2'b00;
          ifa.in_valid = 1'b1;
          @(posedge clk);
          #1;
        end
        ifa.in_valid = 1'b0;
      end
      begin
        int w = 0;
        logic [0:7] e;
        while (!ifa.out_valid && w < 20) begin
          @(posedge clk);
          #1 w++;
        end
        for (int i = 0; i < 8; i++) begin
          e = '0;
          e[i] = 1'b1;
          checks++;
          if (ifa.out_valid !== 1'b1 || ifa.out_data !== e) begin
            errors++;
            $display("FAIL b2b_%0d: v=%b d=%b required 1 %b",
                     i, ifa.out_valid, ifa.out_data, e);
          end
          @(posedge clk);
          #1;
        end
      end
    join
  endtask

  task automatic test_stall();
    int w = 0;
    int p0 = push_a;
    int q0 = pop_a;
    logic [0:7] held;
    ifa.out_ready = 1'b0;
    do begin
      ifa.in_data  = 8'($urandom);
      ifa.in_amt   = 3'($urandom);
      ifa.in_mode  = 2'($urandom);
      ifa.in_valid = 1'b1;
      @(posedge clk);
      #1 w++;
    end while (ifa.in_ready && w < 10);
    checks++;
    if (ifa.out_valid !== 1'b1 || w !== 3) begin
      errors++;
      $display("FAIL stall_fill: out_valid=%b after %0d cycles required 1 after 3",
               ifa.out_valid, w);
    end
    held = ifa.out_data;
    for (int i = 0; i < 5; i++) begin
      ifa.in_data = 8'($urandom);
      ifa.in_amt  = 3'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b1 || ifa.out_data !== held) begin
        errors++;
        $display("FAIL stall_hold_%0d: rdy=%b v=%b d=%b required 0 1 %b",
                 i, ifa.in_ready, ifa.out_valid, ifa.out_data, held);
      end
    end
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifa.in_data = 8'($urandom);
      ifa.in_amt  = 3'($urandom);
      ifa.in_mode = 2'($urandom);
      @(posedge clk);
      #1;
    end
    ifa.in_valid = 1'b0;
    w = 0;
    while (qa.size() != 0 && w < 20) begin
      @(posedge clk);
      #1 w++;
    end
    checks++;
    if (push_a - p0 !== 7 || pop_a - q0 !== 7 || qa.size() != 0) begin
      errors++;
      $display("FAIL stall_count: accepted %0d emitted %0d left %0d required 7 7 0",
               push_a - p0, pop_a - q0, qa.size());
    end
  endtask

  task automatic test_reset_midflight();
    int lat;
    ifa.out_ready = 1'b1;
    ifa.in_data = 8'b10110101; ifa.in_amt = 3'b000; ifa.in_mode = 2'b00;
    ifa.in_valid = 1'b1;
    @(posedge clk);
    #1 ifa.in_data = 8'b01100110;
    @(posedge clk);
    #1 ifa.in_valid = 1'b0;
    ifa.in_data = 8'hff;
    @(posedge clk);
    #1;
    checks++;
    if (ifa.out_valid !== 1'b1 || ifa.out_data !== 8'b10110101) begin
      errors++;
      $display("FAIL rst_pre: v=%b d=%b required 1 10110101",
               ifa.out_valid, ifa.out_data);
    end
    rst = 1'b1;
    qa.delete();
    #1;
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.out_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_async: v=%b d=%b required 0 00000000",
               ifa.out_valid, ifa.out_data);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ifa.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale_%0d: out_valid=%b required 0", i, ifa.out_valid);
      end
    end
    ifa.in_data = 8'b00000110; ifa.in_amt = 3'b010; ifa.in_mode = 2'b01;
    ifa.in_valid = 1'b1;
    @(posedge clk);
    #1 ifa.in_valid = 1'b0;
    lat = 1;
    while (!ifa.out_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    checks++;
    if (lat !== 3 || ifa.out_data !== 8'b00011000) begin
      errors++;
      $display("FAIL rst_first: latency %0d data %b required 3 00011000",
               lat, ifa.out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep();
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          ifb.in_valid  = 1'($urandom_range(0, 1));
          ifb.in_data   = {$urandom(), $urandom()};
          ifb.in_amt    = 6'($urandom_range(0, 63));
          ifb.in_mode   = 2'($urandom);
          ifb.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        ifb.in_valid = 1'b0;
        ifb.out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 400; i++) begin
          ifc.in_valid  = ($urandom_range(0, 3) != 0);
          ifc.in_data   = 16'($urandom);
          ifc.in_amt    = 4'($urandom_range(0, 15));
          ifc.in_mode   = 2'($urandom);
          ifc.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
      end
    join
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (qb.size() != 0 || push_b !== pop_b || push_b < 50) begin
      errors++;
      $display("FAIL sweep_b: accepted %0d emitted %0d left %0d",
               push_b, pop_b, qb.size());
    end
    checks++;
    if (qc.size() != 0 || push_c !== pop_c || push_c < 50) begin
      errors++;
      $display("FAIL sweep_c: accepted %0d emitted %0d left %0d",
               push_c, pop_c, qc.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
